// File: rtl/load_store_unit_if.sv
// Request / data-memory / writeback bundle for load_store_unit.
// The slave modport is the unit's view; the master modport is the surrounding pipeline and memory.
`timescale 1ns/1ps
interface load_store_unit_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic [31:0] data_addr_o;
    logic [31:0] data_write_o;
    logic        data_write_enable_o;
    logic        data_read_enable_o;
    logic [31:0] data_read_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        wb_misalign_o;

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        input  data_read_i, wb_ready_i,
        output req_ready_o, data_addr_o, data_write_o, data_write_enable_o, data_read_enable_o,
        output wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, wb_misalign_o
    );

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        output data_read_i, wb_ready_i,
        input  req_ready_o, data_addr_o, data_write_o, data_write_enable_o, data_read_enable_o,
        input  wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, wb_misalign_o
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller: one request in flight, RMW for sub-word stores over a word-only memory.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses skip memory and report the faulting address.
`timescale 1ns/1ps
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              reset_i,
    load_store_unit_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RESP} state_t;

    localparam logic [29:0] LAST_IDX = 30'(MEM_WORDS);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_we_q, wb_we_d;
    logic        mis_q, mis_d;

    logic        accept, req_oor, req_mis;
    logic [4:0]  shamt;
    logic [31:0] lane_mask, rdata_sh, load_ext, merged;
    logic        sgn;

    assign accept  = bus.req_valid_i && (state_q == S_IDLE);
    assign req_oor = bus.req_addr_i[31:2] >= LAST_IDX;
`ifdef MISALIGN_TRAP_EN
    assign req_mis = ((bus.req_funct3_i[1:0] == 2'b01) && bus.req_addr_i[0]) ||
                     (bus.req_funct3_i[1] && (bus.req_addr_i[1:0] != 2'b00));
`else
    assign req_mis = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            funct3_q  <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rd_q      <= 5'd0;
            wb_data_q <= 32'd0;
            wb_we_q   <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
            wb_we_q   <= wb_we_d;
            mis_q     <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) begin
                if (req_mis || req_oor)                      state_d = S_RESP;
                else if (bus.req_we_i && bus.req_funct3_i[1]) state_d = S_WR;
                else                                          state_d = S_RD;
            end
            S_RD:   state_d = S_CAP;
            S_CAP:  state_d = we_q ? S_WR : S_RESP;
            S_WR:   state_d = S_RESP;
            S_RESP: if (bus.wb_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane select and extension/merge of the word captured from memory.
    always_comb begin
        shamt     = (funct3_q[1:0] == 2'b00) ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
        lane_mask = (funct3_q[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        rdata_sh  = bus.data_read_i >> shamt;
        sgn       = ~funct3_q[2];
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{sgn & rdata_sh[7]}}, rdata_sh[7:0]};
            2'b01:   load_ext = {{16{sgn & rdata_sh[15]}}, rdata_sh[15:0]};
            default: load_ext = bus.data_read_i;
        endcase
        merged = (bus.data_read_i & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);
    end

    always_comb begin
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;
        wb_we_d   = wb_we_q;
        mis_d     = mis_q;
        if (accept) begin
            we_d      = bus.req_we_i;
            funct3_d  = bus.req_funct3_i;
            addr_d    = bus.req_addr_i;
            wdata_d   = bus.req_wdata_i;
            rd_d      = bus.req_rd_i;
            wb_data_d = req_mis ? bus.req_addr_i : 32'd0;
            wb_we_d   = ~bus.req_we_i & ~req_mis;
            mis_d     = req_mis;
        end else if (state_q == S_CAP) begin
            if (we_q) wdata_d   = merged;
            else      wb_data_d = load_ext;
        end
    end

    // Memory strobes come from state only, so reset drops them immediately.
    always_comb begin
        bus.req_ready_o         = (state_q == S_IDLE);
        bus.data_read_enable_o  = (state_q == S_RD);
        bus.data_write_enable_o = (state_q == S_WR);
        bus.data_addr_o         = {2'b00, addr_q[31:2]};
        bus.data_write_o        = wdata_q;
        bus.wb_valid_o          = (state_q == S_RESP);
        bus.wb_we_o             = (state_q == S_RESP) && wb_we_q;
        bus.wb_misalign_o       = (state_q == S_RESP) && mis_q;
        bus.wb_rd_o             = rd_q;
        bus.wb_data_o           = wb_data_q;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a registered-read word memory model.
`timescale 1ns/1ps
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit #(.MEM_WORDS(256)) dut (.clk_i(clk), .reset_i(rst_n), .bus(bus));

    typedef struct packed {logic we; logic mis; logic [4:0] rd; logic [31:0] data;} wb_t;
    typedef struct {logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata; logic [4:0] rd;} req_t;
    typedef struct {wb_t wb; int lat; int nrd; int nwr; int idx; logic [31:0] memw;} exp_t;

    logic [31:0] mem [256];
    int rd_cnt = 0, wr_cnt = 0;
    int n_chk = 0, n_fail = 0;
    exp_t exp_q[$];
    logic [106:0] rst_exp;

    always @(posedge clk) begin
        if (bus.data_write_enable_o) begin
            mem[bus.data_addr_o[7:0]] <= bus.data_write_o;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.data_read_enable_o) begin
            bus.data_read_i <= mem[bus.data_addr_o[7:0]];
            rd_cnt <= rd_cnt + 1;
        end
    end

    function automatic req_t R(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [4:0] rd);
        req_t r; r.we = we; r.f3 = f3; r.addr = addr; r.wdata = wd; r.rd = rd; return r;
    endfunction

    function automatic exp_t X(input logic we, input logic mis, input logic [4:0] rd, input logic [31:0] data,
                               input int lat, input int nrd, input int nwr, input int idx, input logic [31:0] memw);
        exp_t e;
        e.wb.we = we; e.wb.mis = mis; e.wb.rd = rd; e.wb.data = data;
        e.lat = lat; e.nrd = nrd; e.nwr = nwr; e.idx = idx; e.memw = memw;
        return e;
    endfunction

    function automatic wb_t obs();
        wb_t w;
        w.we = bus.wb_we_o; w.mis = bus.wb_misalign_o; w.rd = bus.wb_rd_o; w.data = bus.wb_data_o;
        return w;
    endfunction

    function automatic logic [106:0] outs();
        return {bus.req_ready_o, bus.wb_valid_o, bus.wb_we_o, bus.wb_misalign_o, bus.data_read_enable_o,
                bus.data_write_enable_o, bus.data_addr_o, bus.data_write_o, bus.wb_data_o, bus.wb_rd_o};
    endfunction

    // Drive one request, then count edges (accept edge = 1) until wb_valid_o.
    task automatic run_req(input req_t r, output int lat, output int nrd, output int nwr, output bit to);
        int r0, w0;
        @(negedge clk);
        r0 = rd_cnt; w0 = wr_cnt;
        bus.req_valid_i = 1'b1; bus.req_we_i = r.we; bus.req_funct3_i = r.f3;
        bus.req_addr_i = r.addr; bus.req_wdata_i = r.wdata; bus.req_rd_i = r.rd;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        lat = 1;
        while (!bus.wb_valid_o && lat < 40) begin @(posedge clk); #1; lat++; end
        to = !bus.wb_valid_o;
        nrd = rd_cnt - r0; nwr = wr_cnt - w0;
    endtask

    task automatic finish_resp();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_chk++;
        if (outs() !== rst_exp) begin n_fail++; $display("FAIL reset_values: got %h want %h", outs(), rst_exp); end
    endtask

    task automatic test_store_word();
        req_t rq[2]; exp_t ex[2]; exp_t e; int lat, nrd, nwr; bit to;
        rq[0] = R(1, 3'b010, 32'h08, 32'h8076_54F0, 5'd3); ex[0] = X(0, 0, 5'd3, 0, 2, 0, 1, 2, 32'h8076_54F0);
        rq[1] = R(1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd4); ex[1] = X(0, 0, 5'd4, 0, 2, 0, 1, 4, 32'hDEAD_BEEF);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ex[i]);
            run_req(rq[i], lat, nrd, nwr, to);
            e = exp_q.pop_front();
            n_chk++;
            if (to || obs() !== e.wb) begin n_fail++; $display("FAIL store_word[%0d] wb: got %h want %h", i, obs(), e.wb); end
            n_chk++;
            if (lat != e.lat || nrd != e.nrd || nwr != e.nwr) begin
                n_fail++; $display("FAIL store_word[%0d] lat/rd/wr: got %0d/%0d/%0d want %0d/%0d/%0d", i, lat, nrd, nwr, e.lat, e.nrd, e.nwr);
            end
            n_chk++;
            if (mem[e.idx[7:0]] !== e.memw) begin n_fail++; $display("FAIL store_word[%0d] mem: got %h want %h", i, mem[e.idx[7:0]], e.memw); end
            finish_resp();
        end
    endtask

    task automatic test_loads();
        req_t rq[5]; exp_t ex[5]; exp_t e; int lat, nrd, nwr; bit to;
        rq[0] = R(0, 3'b000, 32'h0B, 0, 5'd1); ex[0] = X(1, 0, 5'd1, 32'hFFFF_FF80, 3, 1, 0, -1, 0);
        rq[1] = R(0, 3'b100, 32'h0B, 0, 5'd2); ex[1] = X(1, 0, 5'd2, 32'h0000_0080, 3, 1, 0, -1, 0);
        rq[2] = R(0, 3'b001, 32'h0A, 0, 5'd3); ex[2] = X(1, 0, 5'd3, 32'hFFFF_8076, 3, 1, 0, -1, 0);
        rq[3] = R(0, 3'b101, 32'h08, 0, 5'd4); ex[3] = X(1, 0, 5'd4, 32'h0000_54F0, 3, 1, 0, -1, 0);
        rq[4] = R(0, 3'b010, 32'h10, 0, 5'd5); ex[4] = X(1, 0, 5'd5, 32'hDEAD_BEEF, 3, 1, 0, -1, 0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(ex[i]);
            run_req(rq[i], lat, nrd, nwr, to);
            e = exp_q.pop_front();
            n_chk++;
            if (to || obs() !== e.wb) begin n_fail++; $display("FAIL loads[%0d] wb: got %h want %h", i, obs(), e.wb); end
            n_chk++;
            if (lat != e.lat || nrd != e.nrd || nwr != e.nwr) begin
                n_fail++; $display("FAIL loads[%0d] lat/rd/wr: got %0d/%0d/%0d want %0d/%0d/%0d", i, lat, nrd, nwr, e.lat, e.nrd, e.nwr);
            end
            finish_resp();
        end
    endtask

    task automatic test_subword_store();
        req_t rq[3]; exp_t ex[3]; exp_t e; int lat, nrd, nwr; bit to;
        rq[0] = R(1, 3'b001, 32'h0A, 32'h0000_1234, 5'd6); ex[0] = X(0, 0, 5'd6, 0, 4, 1, 1, 2, 32'h1234_54F0);
        rq[1] = R(1, 3'b000, 32'h09, 32'hFFFF_FFAB, 5'd7); ex[1] = X(0, 0, 5'd7, 0, 4, 1, 1, 2, 32'h1234_ABF0);
        rq[2] = R(0, 3'b010, 32'h08, 0, 5'd8);             ex[2] = X(1, 0, 5'd8, 32'h1234_ABF0, 3, 1, 0, -1, 0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ex[i]);
            run_req(rq[i], lat, nrd, nwr, to);
            e = exp_q.pop_front();
            n_chk++;
            if (to || obs() !== e.wb) begin n_fail++; $display("FAIL subword[%0d] wb: got %h want %h", i, obs(), e.wb); end
            n_chk++;
            if (lat != e.lat || nrd != e.nrd || nwr != e.nwr) begin
                n_fail++; $display("FAIL subword[%0d] lat/rd/wr: got %0d/%0d/%0d want %0d/%0d/%0d", i, lat, nrd, nwr, e.lat, e.nrd, e.nwr);
            end
            if (e.idx >= 0) begin
                n_chk++;
                if (mem[e.idx[7:0]] !== e.memw) begin n_fail++; $display("FAIL subword[%0d] mem: got %h want %h", i, mem[e.idx[7:0]], e.memw); end
            end
            finish_resp();
        end
    endtask

    task automatic test_out_of_range();
        req_t rq[5]; exp_t ex[5]; exp_t e; int lat, nrd, nwr; bit to;
        rq[0] = R(1, 3'b010, 32'h3FC, 32'hCAFE_F00D, 5'd9); ex[0] = X(0, 0, 5'd9, 0, 2, 0, 1, 255, 32'hCAFE_F00D);
        rq[1] = R(0, 3'b010, 32'h3FC, 0, 5'd10);            ex[1] = X(1, 0, 5'd10, 32'hCAFE_F00D, 3, 1, 0, -1, 0);
        rq[2] = R(0, 3'b010, 32'h400, 0, 5'd11);            ex[2] = X(1, 0, 5'd11, 0, 1, 0, 0, -1, 0);
        rq[3] = R(1, 3'b000, 32'h400, 32'h11, 5'd12);       ex[3] = X(0, 0, 5'd12, 0, 1, 0, 0, -1, 0);
        rq[4] = R(0, 3'b100, 32'hFFFF_FFFC, 0, 5'd13);      ex[4] = X(1, 0, 5'd13, 0, 1, 0, 0, -1, 0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(ex[i]);
            run_req(rq[i], lat, nrd, nwr, to);
            e = exp_q.pop_front();
            n_chk++;
            if (to || obs() !== e.wb) begin n_fail++; $display("FAIL range[%0d] wb: got %h want %h", i, obs(), e.wb); end
            n_chk++;
            if (lat != e.lat || nrd != e.nrd || nwr != e.nwr) begin
                n_fail++; $display("FAIL range[%0d] lat/rd/wr: got %0d/%0d/%0d want %0d/%0d/%0d", i, lat, nrd, nwr, e.lat, e.nrd, e.nwr);
            end
            finish_resp();
        end
    endtask

    task automatic test_reset_mid_rmw();
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_funct3_i = 3'b000;
        bus.req_addr_i = 32'h10; bus.req_wdata_i = 32'h55; bus.req_rd_i = 5'd0;
        @(posedge clk); #1; bus.req_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_chk++;
        if (bus.data_write_enable_o !== 1'b1 || bus.data_write_o !== 32'hDEAD_BE55) begin
            n_fail++; $display("FAIL rmw_wr_phase: got we=%b data=%h want we=1 data=deadbe55", bus.data_write_enable_o, bus.data_write_o);
        end
        rst_n = 1'b0; #1;
        n_chk++;
        if (outs() !== rst_exp) begin n_fail++; $display("FAIL reset_mid_rmw: got %h want %h", outs(), rst_exp); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (mem[4] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rmw_mem_kept: got %h want deadbeef", mem[4]); end
    endtask

    task automatic test_misalign();
        req_t rq[3]; exp_t ex[3]; exp_t e; int lat, nrd, nwr; bit to;
        rq[0] = R(0, 3'b010, 32'h13, 0, 5'd14);
        rq[1] = R(0, 3'b001, 32'h0B, 0, 5'd15);
        rq[2] = R(1, 3'b010, 32'h06, 32'h1, 5'd16);
`ifdef MISALIGN_TRAP_EN
        ex[0] = X(0, 1, 5'd14, 32'h13, 1, 0, 0, -1, 0);
        ex[1] = X(0, 1, 5'd15, 32'h0B, 1, 0, 0, -1, 0);
        ex[2] = X(0, 1, 5'd16, 32'h06, 1, 0, 0, -1, 0);
`else
        ex[0] = X(1, 0, 5'd14, 32'hDEAD_BEEF, 3, 1, 0, -1, 0);
        ex[1] = X(1, 0, 5'd15, 32'h0000_1234, 3, 1, 0, -1, 0);
        ex[2] = X(0, 0, 5'd16, 0, 2, 0, 1, 1, 32'h1);
`endif
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ex[i]);
            run_req(rq[i], lat, nrd, nwr, to);
            e = exp_q.pop_front();
            n_chk++;
            if (to || obs() !== e.wb) begin n_fail++; $display("FAIL misalign[%0d] wb: got %h want %h", i, obs(), e.wb); end
            n_chk++;
            if (lat != e.lat || nrd != e.nrd || nwr != e.nwr) begin
                n_fail++; $display("FAIL misalign[%0d] lat/rd/wr: got %0d/%0d/%0d want %0d/%0d/%0d", i, lat, nrd, nwr, e.lat, e.nrd, e.nwr);
            end
            if (e.idx >= 0) begin
                n_chk++;
                if (mem[e.idx[7:0]] !== e.memw) begin n_fail++; $display("FAIL misalign[%0d] mem: got %h want %h", i, mem[e.idx[7:0]], e.memw); end
            end
            finish_resp();
        end
    endtask

    task automatic test_backpressure();
        exp_t e; int lat, nrd, nwr, w0; bit to;
        bus.wb_ready_i = 1'b0;
        exp_q.push_back(X(1, 0, 5'd17, 32'h0000_00F0, 3, 1, 0, -1, 0));
        run_req(R(0, 3'b100, 32'h08, 0, 5'd17), lat, nrd, nwr, to);
        e = exp_q.pop_front();
        n_chk++;
        if (to || obs() !== e.wb || lat != e.lat) begin n_fail++; $display("FAIL stall_first: got %h lat %0d want %h lat %0d", obs(), lat, e.wb, e.lat); end
        // A competing store is held valid during the stall and must not be taken.
        w0 = wr_cnt;
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_funct3_i = 3'b010; bus.req_addr_i = 32'h20;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_chk++;
            if (obs() !== e.wb || bus.wb_valid_o !== 1'b1 || bus.req_ready_o !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %h v=%b rdy=%b want %h v=1 rdy=0", c, obs(), bus.wb_valid_o, bus.req_ready_o, e.wb);
            end
        end
        @(negedge clk); bus.req_valid_i = 1'b0; bus.wb_ready_i = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (bus.req_ready_o !== 1'b1 || bus.wb_valid_o !== 1'b0 || wr_cnt != w0) begin
            n_fail++; $display("FAIL stall_release: got rdy=%b v=%b wr=%0d want rdy=1 v=0 wr=%0d", bus.req_ready_o, bus.wb_valid_o, wr_cnt, w0);
        end
    endtask

    task automatic test_back_to_back();
        req_t rq[2]; exp_t ex[2]; exp_t e; int lat, nrd, nwr; bit to;
        rq[0] = R(0, 3'b010, 32'h10, 0, 5'd18); ex[0] = X(1, 0, 5'd18, 32'hDEAD_BEEF, 3, 1, 0, -1, 0);
        rq[1] = R(0, 3'b010, 32'h08, 0, 5'd19); ex[1] = X(1, 0, 5'd19, 32'h1234_ABF0, 3, 1, 0, -1, 0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ex[i]);
            run_req(rq[i], lat, nrd, nwr, to);
            e = exp_q.pop_front();
            n_chk++;
            if (to || obs() !== e.wb || lat != e.lat) begin n_fail++; $display("FAIL b2b[%0d]: got %h lat %0d want %h lat %0d", i, obs(), lat, e.wb, e.lat); end
            finish_resp();
            n_chk++;
            if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.req_ready_o); end
        end
    endtask

    initial begin
        rst_exp = {1'b1, 106'd0};
        rst_n = 1'b0;
        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_funct3_i = 3'd0;
        bus.req_addr_i = 32'd0; bus.req_wdata_i = 32'd0; bus.req_rd_i = 5'd0;
        bus.wb_ready_i = 1'b1;
        #12;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        test_store_word();
        test_loads();
        test_subword_store();
        test_out_of_range();
        test_reset_mid_rmw();
        test_misalign();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
